cnt_target_seeker: RTL and testbench

- Control stage directly upstream of the saturating up/down counter.
  - Drives the counter's mode input.
  - Takes the counter's signed 10-bit cnt back as feedback.
- Accepts a target value over a valid/ready handshake and steers the counter toward it.
- Reports completion with an ok flag and the signed overshoot error.
- Detects unreachable targets (saturation stall) and timeouts.

---
 rtl/cnt_target_seeker.sv | 160 ++++++++++++++++
 tb/tb_cnt_target_seeker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_target_seeker.sv
// cnt_target_seeker
//
// Control stage that sits directly in front of the saturating up/down
// counter. It accepts a signed target over a valid/ready handshake. It
// then drives the counter's mode input so that the fed-back cnt moves
// toward the target. When the seek ends, it reports the result with a
// one-cycle done pulse, an ok flag and the signed overshoot error.
//
// A seek ends in one of three ways, checked in this priority order:
//   - reached : cnt crossed or hit the target            (ok = 1)
//   - stall   : cnt stopped moving, i.e. counter saturated (ok = 0)
//   - timeout : TIMEOUT + 1 seek cycles elapsed            (ok = 0)
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   cmd_valid   target command present
//   cmd_target  signed 10-bit target value
//   cmd_ready   high only while idle; an accept is cmd_valid & cmd_ready
//   cnt         signed 10-bit counter value fed back from the counter
//   mode        1 = count up, 0 = count down; IDLE_MODE when not seeking
//   busy        high while seeking up or down
//   done        one-cycle completion pulse
//   ok          qualified by done: 1 = target reached, 0 = stall/timeout
//   err         signed cnt - target at completion, held until next report
//
// Parameters:
//   IDLE_MODE   mode value driven while not seeking
//   TIMEOUT     last timer value allowed in a seek state (1..255)

module cnt_target_seeker #(
    parameter logic IDLE_MODE = 1'b0,
    parameter int   TIMEOUT   = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic signed [9:0]  cmd_target,
    output logic               cmd_ready,
    input  logic signed [9:0]  cnt,
    output logic               mode,
    output logic               busy,
    output logic               done,
    output logic               ok,
    output logic signed [10:0] err
);

    localparam logic [7:0] TIMEOUT_T = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEEK_UP   = 2'd1,
        SEEK_DOWN = 2'd2,
        REPORT    = 2'd3
    } state_t;

    state_t             state;
    logic signed [9:0]  target;
    logic signed [9:0]  prev_cnt;
    logic [7:0]         timer;

    // Sign-extend both operands to 11 bits before subtracting. This way
    // the full -1023..+1023 difference is representable without overflow.
    function automatic logic signed [10:0] diff11(input logic signed [9:0] a,
                                                  input logic signed [9:0] b);
        return {a[9], a} - {b[9], b};
    endfunction

    // A stall means cnt did not move since the previous edge. The first
    // seek cycle is excluded, because prev_cnt then still reflects the
    // counter running in idle mode.
    logic stalled;
    assign stalled = (timer != 8'd0) && (cnt == prev_cnt);

    // These status outputs are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SEEK_UP) || (state == SEEK_DOWN);
    assign done      = (state == REPORT);

    // mode follows the state directly. This lets the counter see the new
    // direction in the cycle right after an accept.
    always_comb begin
        mode = IDLE_MODE;
        case (state)
            SEEK_UP:   mode = 1'b1;
            SEEK_DOWN: mode = 1'b0;
            default:   mode = IDLE_MODE;
        endcase
    end

    // Main controller. Reached uses >= / <= rather than ==, because the
    // counter can jump over values and an exact match might never occur.
    // err is only written on the way into REPORT, so it holds between seeks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            target   <= '0;
            prev_cnt <= '0;
            timer    <= '0;
            ok       <= 1'b0;
            err      <= '0;
        end else begin
            prev_cnt <= cnt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target <= cmd_target;
                        timer  <= '0;
                        if (cnt < cmd_target) begin
                            state <= SEEK_UP;
                        end else if (cnt > cmd_target) begin
                            state <= SEEK_DOWN;
                        end else begin
                            state <= REPORT;
                            ok    <= 1'b1;
                            err   <= diff11(cnt, cmd_target);
                        end
                    end
                end

                SEEK_UP: begin
                    if (cnt >= target) begin
                        state <= REPORT;
                        ok    <= 1'b1;
                        err   <= diff11(cnt, target);
                    end else if (stalled || (timer == TIMEOUT_T)) begin
                        state <= REPORT;
                        ok    <= 1'b0;
                        err   <= diff11(cnt, target);
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                SEEK_DOWN: begin
                    if (cnt <= target) begin
                        state <= REPORT;
                        ok    <= 1'b1;
                        err   <= diff11(cnt, target);
                    end else if (stalled || (timer == TIMEOUT_T)) begin
                        state <= REPORT;
                        ok    <= 1'b0;
                        err   <= diff11(cnt, target);
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                REPORT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_target_seeker.sv
// tb_cnt_target_seeker
//
// Directed bench for cnt_target_seeker. The bench plays the role of the
// counter by driving cnt directly, one value per clock.
//
// Whenever a command is issued that should end in a report, the expected
// ok/err pair is queued. A separate monitor pops that pair on every done
// pulse and compares it against the DUT outputs.

module tb_cnt_target_seeker;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic signed [9:0]  cmd_target = '0;
    logic signed [9:0]  cnt = '0;
    logic               cmd_ready;
    logic               mode;
    logic               busy;
    logic               done;
    logic               ok;
    logic signed [10:0] err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic exp_ok;
        int   exp_err;
    } exp_t;

    exp_t exp_q[$];

    cnt_target_seeker #(
        .IDLE_MODE (1'b0),
        .TIMEOUT   (127)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_target (cmd_target),
        .cmd_ready  (cmd_ready),
        .cnt        (cnt),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .ok         (ok),
        .err        (err)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then land just after the next rising
    // edge, so that direct checks see the post-edge state.
    task automatic applyStimulus(input logic v, input int tgt, input int c);
        cmd_valid  = v;
        cmd_target = 10'(tgt);
        cnt        = 10'(c);
        @(posedge clk);
        #1;
    endtask

    // Queue the ok/err pair expected on the next done pulse.
    task automatic expectDone(input logic o, input int e);
        exp_t x;
        x.exp_ok  = o;
        x.exp_err = e;
        exp_q.push_back(x);
    endtask

    // Monitor: on every done pulse, sampled mid-cycle, pop the expected
    // pair and compare it. A done pulse with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_ok", int'(ok), int'(e.exp_ok));
                checkOutput("done_err", int'(err), e.exp_err);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held two cycles with a command pending: nothing may be accepted.
        rst        = 1'b1;
        cmd_valid  = 1'b1;
        cmd_target = 10'sd5;
        cnt        = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 5, 0);
        checkOutput("post_reset_ready", int'(cmd_ready), 1);
        checkOutput("post_reset_busy", int'(busy), 0);

        // Seek up from -50 to 0 in steps of 5, landing exactly on the target.
        expectDone(1'b1, 0);
        applyStimulus(1'b1, 0, -50);
        checkOutput("up_mode", int'(mode), 1);
        checkOutput("up_busy", int'(busy), 1);
        checkOutput("up_ready", int'(cmd_ready), 0);
        for (int v = -45; v <= 0; v += 5) applyStimulus(1'b0, 0, v);
        checkOutput("up_done", int'(done), 1);
        checkOutput("up_report_ready", int'(cmd_ready), 0);
        checkOutput("up_report_mode", int'(mode), 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("up_back_idle", int'(cmd_ready), 1);
        checkOutput("up_done_cleared", int'(done), 0);

        // Seek down from -50 to -100 in steps of 9; overshoot to -104 gives err = -4.
        expectDone(1'b1, -4);
        applyStimulus(1'b1, -100, -50);
        checkOutput("down_mode", int'(mode), 0);
        checkOutput("down_busy", int'(busy), 1);
        for (int v = -59; v >= -104; v -= 9) applyStimulus(1'b0, -100, v);
        checkOutput("down_done", int'(done), 1);
        applyStimulus(1'b0, -100, -104);

        // Unreachable target: cnt sticks at 235, so stall gives ok = 0, err = -5.
        expectDone(1'b0, -5);
        applyStimulus(1'b1, 240, 230);
        checkOutput("stall_mode", int'(mode), 1);
        applyStimulus(1'b0, 240, 235);
        checkOutput("stall_first_cycle_busy", int'(busy), 1);
        applyStimulus(1'b0, 240, 235);
        checkOutput("stall_done", int'(done), 1);
        applyStimulus(1'b0, 240, 235);

        // Equal target: report on the very next cycle, and mode never goes up.
        expectDone(1'b1, 0);
        applyStimulus(1'b1, -50, -50);
        checkOutput("equal_done", int'(done), 1);
        checkOutput("equal_mode", int'(mode), 0);
        checkOutput("equal_busy", int'(busy), 0);
        applyStimulus(1'b0, -50, -50);
        checkOutput("equal_idle_mode", int'(mode), 0);

        // Timeout: cnt alternates 1/0, so it neither stalls nor reaches 100.
        // Edge 127 (timer == 127) ends the seek while cnt = 0, so err = -100.
        expectDone(1'b0, -100);
        applyStimulus(1'b1, 100, 0);
        for (int k = 0; k < 128; k++) begin
            applyStimulus(1'b0, 100, (k % 2 == 0) ? 1 : 0);
            if (k == 126) begin
                checkOutput("timeout_still_busy", int'(busy), 1);
                checkOutput("timeout_not_early", int'(done), 0);
            end
        end
        checkOutput("timeout_done", int'(done), 1);
        applyStimulus(1'b0, 100, 0);

        // Reset in the middle of a seek: back to idle, err cleared, no done pulse.
        applyStimulus(1'b1, 0, -50);
        applyStimulus(1'b0, 0, -45);
        applyStimulus(1'b0, 0, -40);
        checkOutput("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        applyStimulus(1'b0, 0, -35);
        rst = 1'b0;
        checkOutput("abort_ready", int'(cmd_ready), 1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_err", int'(err), 0);
        applyStimulus(1'b0, 0, -35);
        checkOutput("abort_no_late_done", int'(done), 0);

        // A command pulsed while busy must be ignored. If target were replaced
        // by -200, the seek would end early at cnt = -30.
        expectDone(1'b1, 5);
        applyStimulus(1'b1, 0, -50);
        checkOutput("ignore_busy", int'(busy), 1);
        applyStimulus(1'b1, -200, -40);
        checkOutput("ignore_mode", int'(mode), 1);
        checkOutput("ignore_still_busy", int'(busy), 1);
        applyStimulus(1'b0, 0, -30);
        checkOutput("ignore_no_early_done", int'(done), 0);
        applyStimulus(1'b0, 0, -20);
        applyStimulus(1'b0, 0, -10);
        applyStimulus(1'b0, 0, 5);
        checkOutput("ignore_done", int'(done), 1);
        applyStimulus(1'b0, 0, 5);

        applyStimulus(1'b0, 0, 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
